// File: rtl/instr_encoder.sv
// MIPS instruction encoder. It accepts an instruction class and its fields over
// valid/ready and writes the encoded word to instruction memory at the next free address.
module instr_encoder #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2:0]            i_op,
    input  logic [4:0]            i_rs,
    input  logic [4:0]            i_rt,
    input  logic [4:0]            i_rd,
    input  logic [4:0]            i_shamt,
    input  logic [5:0]            i_funct,
    input  logic [15:0]           i_imm,
    input  logic [25:0]           i_target,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [31:0]           o_wr_data,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        WRITE  = 2'd2,
        FULL   = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } fields_t;

    localparam logic [ADDR_WIDTH:0]   CAPACITY  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    fields_t               fields_q, fields_d;
    logic [31:0]           word_q, word_d, word_enc;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d, count_inc;
    logic                  wr_en_q, wr_en_d;

    always_comb begin
        word_enc = {6'b000010, fields_q.target};
        case (fields_q.op)
            3'd0: word_enc = {6'b000000, fields_q.rs, fields_q.rt, fields_q.rd,
                              fields_q.shamt, fields_q.funct};
            3'd1: word_enc = {6'b001000, fields_q.rs, fields_q.rt, fields_q.imm};
            3'd2: word_enc = {6'b001100, fields_q.rs, fields_q.rt, fields_q.imm};
            3'd3: word_enc = {6'b100011, fields_q.rs, fields_q.rt, fields_q.imm};
            3'd4: word_enc = {6'b101011, fields_q.rs, fields_q.rt, fields_q.imm};
            3'd5: word_enc = {6'b000100, fields_q.rs, fields_q.rt, fields_q.imm};
            3'd6: word_enc = {6'b000101, fields_q.rs, fields_q.rt, fields_q.imm};
            default: word_enc = {6'b000010, fields_q.target};
        endcase
    end

    assign count_inc = count_q + COUNT_ONE;

    // Clear wins over every state; the strobe is registered so it lines up with WRITE.
    always_comb begin
        state_d  = state_q;
        fields_d = fields_q;
        word_d   = word_q;
        ptr_d    = ptr_q;
        count_d  = count_q;
        wr_en_d  = 1'b0;
        if (i_clear) begin
            state_d = IDLE;
            ptr_d   = '0;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        fields_d = {i_op, i_rs, i_rt, i_rd, i_shamt, i_funct, i_imm, i_target};
                        state_d  = ENCODE;
                    end
                end
                ENCODE: begin
                    word_d  = word_enc;
                    wr_en_d = 1'b1;
                    state_d = WRITE;
                end
                WRITE: begin
                    count_d = count_inc;
                    if (count_inc == CAPACITY) begin
                        state_d = FULL;
                    end else begin
                        ptr_d   = ptr_q + PTR_ONE;
                        state_d = IDLE;
                    end
                end
                default: state_d = FULL;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            fields_q <= '0;
            word_q   <= '0;
            ptr_q    <= '0;
            count_q  <= '0;
            wr_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            fields_q <= fields_d;
            word_q   <= word_d;
            ptr_q    <= ptr_d;
            count_q  <= count_d;
            wr_en_q  <= wr_en_d;
        end
    end

    assign o_ready   = (state_q == IDLE);
    assign o_full    = (state_q == FULL);
    assign o_wr_en   = wr_en_q;
    assign o_wr_addr = ptr_q;
    assign o_wr_data = word_q;
    assign o_count   = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default-size instance for encoding and abort
// scenarios, and a 4-word instance for the fill/full/clear boundary.
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        clear, valid, clear2, valid2;
    logic [2:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;

    logic        ready, wr_en, full;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [6:0]  count;

    logic        ready2, wr_en2, full2;
    logic [1:0]  wr_addr2;
    logic [31:0] wr_data2;
    logic [2:0]  count2;

    int checks   = 0;
    int failures = 0;

    instr_encoder #(.ADDR_WIDTH(6)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_valid(valid), .o_ready(ready),
        .i_op(op), .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_shamt(shamt), .i_funct(funct),
        .i_imm(imm), .i_target(target), .o_wr_en(wr_en), .o_wr_addr(wr_addr),
        .o_wr_data(wr_data), .o_count(count), .o_full(full)
    );

    instr_encoder #(.ADDR_WIDTH(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear2), .i_valid(valid2), .o_ready(ready2),
        .i_op(op), .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_shamt(shamt), .i_funct(funct),
        .i_imm(imm), .i_target(target), .o_wr_en(wr_en2), .o_wr_addr(wr_addr2),
        .o_wr_data(wr_data2), .o_count(count2), .o_full(full2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [2:0] f_op, input logic [4:0] f_rs, input logic [4:0] f_rt,
                              input logic [4:0] f_rd, input logic [4:0] f_sh, input logic [5:0] f_fn,
                              input logic [15:0] f_imm, input logic [25:0] f_tgt);
        op = f_op; rs = f_rs; rt = f_rt; rd = f_rd; shamt = f_sh; funct = f_fn;
        imm = f_imm; target = f_tgt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (ready !== 1'b1 || wr_en !== 1'b0 || full !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: ready=%b wr_en=%b full=%b expected 1 0 0", ready, wr_en, full);
        end
        checks++;
        if (count !== 7'd0 || wr_addr !== 6'd0 || wr_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_regs: count=%0d addr=%0d data=%h expected 0 0 0", count, wr_addr, wr_data);
        end
        checks++;
        if (ready2 !== 1'b1 || count2 !== 3'd0 || full2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_small: ready=%b count=%0d full=%b expected 1 0 0", ready2, count2, full2);
        end
    endtask

    task automatic test_rtype();
        set_fields(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hABCD, 26'h2AAAAAA);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        set_fields(3'd7, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF);
        checks++;
        if (ready !== 1'b0 || wr_en !== 1'b0) begin
            failures++;
            $display("FAIL rtype_encode: ready=%b wr_en=%b expected 0 0", ready, wr_en);
        end
        tick();
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_data !== 32'h00221820) begin
            failures++;
            $display("FAIL rtype_write: wr_en=%b addr=%0d data=%h expected 1 0 00221820", wr_en, wr_addr, wr_data);
        end
        tick();
        checks++;
        if (wr_en !== 1'b0 || ready !== 1'b1 || count !== 7'd1 || wr_data !== 32'h00221820) begin
            failures++;
            $display("FAIL rtype_after: wr_en=%b ready=%b count=%0d data=%h expected 0 1 1 00221820",
                     wr_en, ready, count, wr_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_data [3];
        int n;
        exp_data[0] = 32'h8FA80004;
        exp_data[1] = 32'h1022FFFF;
        exp_data[2] = 32'h08000010;
        valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: set_fields(3'd3, 5'd29, 5'd8, 5'd31, 5'd17, 6'h3F, 16'h0004, 26'h3FFFFFF);
                1: set_fields(3'd5, 5'd1, 5'd2, 5'd9, 5'd9, 6'h15, 16'hFFFF, 26'h1555555);
                default: set_fields(3'd7, 5'd31, 5'd30, 5'd29, 5'd28, 6'h2A, 16'h8001, 26'h0000010);
            endcase
            checks++;
            if (ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready_%0d: ready=%b expected 1", i, ready);
            end
            tick();
            n = 0;
            while (wr_en !== 1'b1 && n < 5) begin
                tick();
                n++;
            end
            checks++;
            if (n != 1 || wr_addr !== 6'(i + 1) || wr_data !== exp_data[i]) begin
                failures++;
                $display("FAIL b2b_write_%0d: cycles=%0d addr=%0d data=%h expected 1 %0d %h",
                         i, n, wr_addr, wr_data, i + 1, exp_data[i]);
            end
            tick();
        end
        valid = 1'b0;
        checks++;
        if (count !== 7'd4 || wr_en !== 1'b0) begin
            failures++;
            $display("FAIL b2b_count: count=%0d wr_en=%b expected 4 0", count, wr_en);
        end
    endtask

    task automatic test_fill();
        logic [31:0] exp;
        logic        seen;
        for (int i = 0; i < 4; i++) begin
            set_fields(3'd1, 5'(i), 5'd0, 5'd31, 5'd31, 6'h3F, 16'(i), 26'h3FFFFFF);
            exp = 32'h20000000 | (32'(i) << 21) | 32'(i);
            valid2 = 1'b1;
            tick();
            valid2 = 1'b0;
            tick();
            checks++;
            if (wr_en2 !== 1'b1 || wr_addr2 !== 2'(i) || wr_data2 !== exp) begin
                failures++;
                $display("FAIL fill_write_%0d: wr_en=%b addr=%0d data=%h expected 1 %0d %h",
                         i, wr_en2, wr_addr2, wr_data2, i, exp);
            end
            tick();
        end
        checks++;
        if (full2 !== 1'b1 || ready2 !== 1'b0 || count2 !== 3'd4) begin
            failures++;
            $display("FAIL fill_full: full=%b ready=%b count=%0d expected 1 0 4", full2, ready2, count2);
        end
        valid2 = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (wr_en2 === 1'b1) seen = 1'b1;
        end
        valid2 = 1'b0;
        checks++;
        if (seen !== 1'b0 || count2 !== 3'd4 || full2 !== 1'b1) begin
            failures++;
            $display("FAIL fill_fifth: wrote=%b count=%0d full=%b expected 0 4 1", seen, count2, full2);
        end
        clear2 = 1'b1;
        tick();
        clear2 = 1'b0;
        checks++;
        if (count2 !== 3'd0 || ready2 !== 1'b1 || full2 !== 1'b0) begin
            failures++;
            $display("FAIL fill_clear: count=%0d ready=%b full=%b expected 0 1 0", count2, ready2, full2);
        end
        set_fields(3'd1, 5'd7, 5'd0, 5'd0, 5'd0, 6'h00, 16'h1234, 26'h0);
        valid2 = 1'b1;
        tick();
        valid2 = 1'b0;
        tick();
        checks++;
        if (wr_en2 !== 1'b1 || wr_addr2 !== 2'd0 || wr_data2 !== 32'h20E01234) begin
            failures++;
            $display("FAIL fill_restart: wr_en=%b addr=%0d data=%h expected 1 0 20e01234", wr_en2, wr_addr2, wr_data2);
        end
        tick();
        checks++;
        if (count2 !== 3'd1) begin
            failures++;
            $display("FAIL fill_restart_count: count=%0d expected 1", count2);
        end
    endtask

    task automatic test_abort_reset();
        logic seen;
        set_fields(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0005, 26'h0);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || wr_en !== 1'b0 || full !== 1'b0 || count !== 7'd0 ||
            wr_addr !== 6'd0 || wr_data !== 32'd0) begin
            failures++;
            $display("FAIL abort_reset_now: ready=%b wr_en=%b full=%b count=%0d addr=%0d data=%h expected 1 0 0 0 0 0",
                     ready, wr_en, full, count, wr_addr, wr_data);
        end
        tick(); tick();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (wr_en === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || count !== 7'd0 || ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_reset_after: wrote=%b count=%0d ready=%b expected 0 0 1", seen, count, ready);
        end
    endtask

    task automatic test_abort_clear();
        logic seen;
        set_fields(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick(); tick();
        set_fields(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0005, 26'h0);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (ready !== 1'b1 || wr_en !== 1'b0 || count !== 7'd0 || wr_addr !== 6'd0 ||
            wr_data !== 32'h00221820) begin
            failures++;
            $display("FAIL abort_clear_encode: ready=%b wr_en=%b count=%0d addr=%0d data=%h expected 1 0 0 0 00221820",
                     ready, wr_en, count, wr_addr, wr_data);
        end
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (wr_en === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_clear_nowrite: wrote=%b expected 0", seen);
        end
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_data !== 32'h20220005) begin
            failures++;
            $display("FAIL clear_in_write_strobe: wr_en=%b addr=%0d data=%h expected 1 0 20220005", wr_en, wr_addr, wr_data);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (count !== 7'd0 || wr_en !== 1'b0 || ready !== 1'b1 || wr_addr !== 6'd0) begin
            failures++;
            $display("FAIL clear_in_write_after: count=%0d wr_en=%b ready=%b addr=%0d expected 0 0 1 0",
                     count, wr_en, ready, wr_addr);
        end
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_data !== 32'h20220005) begin
            failures++;
            $display("FAIL abort_clear_retry: wr_en=%b addr=%0d data=%h expected 1 0 20220005", wr_en, wr_addr, wr_data);
        end
        tick();
        checks++;
        if (count !== 7'd1) begin
            failures++;
            $display("FAIL abort_clear_count: count=%0d expected 1", count);
        end
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; valid = 1'b0; clear2 = 1'b0; valid2 = 1'b0;
        set_fields(3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
        test_reset();
        test_rtype();
        test_back_to_back();
        test_fill();
        test_abort_reset();
        test_abort_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
